// File: rtl/if_prefetch_stage.sv
// Instruction-fetch stage: PC generator, in-order imem request/response port and a
// DEPTH-entry prefetch queue that presents instructions to ID over valid/ready.
module if_prefetch_stage #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       dbg_run,
    input  logic                       redirect_valid,
    input  logic [XLEN-1:0]            redirect_pc,
    output logic                       imem_req_valid,
    input  logic                       imem_req_ready,
    output logic [XLEN-1:0]            imem_req_addr,
    input  logic                       imem_rsp_valid,
    input  logic [XLEN-1:0]            imem_rsp_data,
    output logic                       id_valid,
    input  logic                       id_ready,
    output logic [XLEN-1:0]            id_pc_plus4,
    output logic [XLEN-1:0]            id_instr,
    output logic [XLEN-1:0]            pc_out,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH+1);
    // Back-to-back redirects can stack stale fetches beyond one queue's worth.
    localparam int DROP_W = CNT_W + 2;

    function automatic logic [XLEN-1:0] align4(input logic [XLEN-1:0] a);
        return a & ~XLEN'(3);
    endfunction

    logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [PTR_W-1:0]  fill_q, fill_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  out_q, out_d;
    logic [DROP_W-1:0] drop_q, drop_d;
    logic [DEPTH-1:0]  dv_q, dv_d;

    logic [XLEN-1:0]   pc4_q   [DEPTH];
    logic [XLEN-1:0]   instr_q [DEPTH];

    logic req_fire;
    logic pop;
    logic head_rdy;
    logic rsp_take;
    logic rsp_drop;
    logic rsp_stale;

    assign imem_req_valid = rst && dbg_run && !redirect_valid && (cnt_q < CNT_W'(DEPTH));
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign imem_req_addr  = fetch_pc_q;
    assign pc_out         = fetch_pc_q;
    assign occupancy      = cnt_q;

    assign head_rdy    = (cnt_q != '0) && dv_q[head_q];
    assign id_valid    = dbg_run && !redirect_valid && head_rdy;
    assign pop         = id_valid && id_ready;
    assign id_instr    = head_rdy ? instr_q[head_q] : '0;
    assign id_pc_plus4 = head_rdy ? pc4_q[head_q] : '0;

    // Stale responses are consumed before any response may fill a live slot.
    assign rsp_drop  = imem_rsp_valid && !redirect_valid && (drop_q != '0);
    assign rsp_take  = imem_rsp_valid && !redirect_valid && (drop_q == '0) && (out_q != '0);
    assign rsp_stale = imem_rsp_valid && ((drop_q != '0) || (out_q != '0));

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        head_d     = head_q;
        tail_d     = tail_q;
        fill_d     = fill_q;
        cnt_d      = cnt_q;
        out_d      = out_q;
        drop_d     = drop_q;
        dv_d       = dv_q;
        if (redirect_valid) begin
            fetch_pc_d = align4(redirect_pc);
            head_d     = '0;
            tail_d     = '0;
            fill_d     = '0;
            cnt_d      = '0;
            out_d      = '0;
            dv_d       = '0;
            drop_d     = drop_q + DROP_W'(out_q) - DROP_W'(rsp_stale);
        end else begin
            if (rsp_drop) begin
                drop_d = drop_q - DROP_W'(1);
            end
            if (rsp_take) begin
                dv_d[fill_q] = 1'b1;
                fill_d       = fill_q + PTR_W'(1);
            end
            if (pop) begin
                dv_d[head_q] = 1'b0;
                head_d       = head_q + PTR_W'(1);
            end
            if (req_fire) begin
                dv_d[tail_q] = 1'b0;
                tail_d       = tail_q + PTR_W'(1);
                fetch_pc_d   = fetch_pc_q + XLEN'(4);
            end
            cnt_d = cnt_q + CNT_W'(req_fire) - CNT_W'(pop);
            out_d = out_q + CNT_W'(req_fire) - CNT_W'(rsp_take);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_q <= RESET_PC;
            head_q     <= '0;
            tail_q     <= '0;
            fill_q     <= '0;
            cnt_q      <= '0;
            out_q      <= '0;
            drop_q     <= '0;
            dv_q       <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            fill_q     <= fill_d;
            cnt_q      <= cnt_d;
            out_q      <= out_d;
            drop_q     <= drop_d;
            dv_q       <= dv_d;
        end
    end

    // Slot payload: PC+4 captured at allocation, instruction at response.
    always_ff @(posedge clk) begin
        if (req_fire) begin
            pc4_q[tail_q] <= fetch_pc_q + XLEN'(4);
        end
        if (rsp_take) begin
            instr_q[fill_q] <= imem_rsp_data;
        end
    end

endmodule

// File: tb/tb_if_prefetch_stage.sv
// Bench for if_prefetch_stage: directed vector table, corner sequences and randomized
// traffic against a queue-based model of the fetch stream and an in-order memory.
module tb_if_prefetch_stage;

    localparam int          DEPTH  = 4;
    localparam logic [31:0] RST_PC = 32'h100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        dbg_run = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req_ready = 1'b0;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        id_ready = 1'b0;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        id_valid;
    logic [31:0] id_pc_plus4;
    logic [31:0] id_instr;
    logic [31:0] pc_out;
    logic [2:0]  occupancy;

    if_prefetch_stage #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
        .clk(clk), .rst(rst), .dbg_run(dbg_run),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .id_valid(id_valid), .id_ready(id_ready),
        .id_pc_plus4(id_pc_plus4), .id_instr(id_instr), .pc_out(pc_out),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; bit landed; } slot_t;
    typedef struct { logic [31:0] addr; int due; } mreq_t;
    typedef struct { int reps; bit idr; bit rv; logic [31:0] addr; bit iv; logic [31:0] pc4; int occ; } vec_t;

    slot_t       slots[$];
    mreq_t       mem_q[$];
    logic [31:0] log_q[$];
    int          drop_m = 0;
    logic [31:0] ref_pc = RST_PC;
    int          cyc = 0, last_due = 0, lat_min = 1, lat_max = 1;
    int          n_chk = 0, n_pass = 0;
    bit          c_dbg, c_redir, c_idr, c_reqr, c_rsp, c_erv, c_eiv;
    logic [31:0] c_rpc;
    vec_t        tbl[12];

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_chk++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, want, cyc);
    endtask

    task automatic do_reset();
        rst = 1'b0; dbg_run = 1'b0; redirect_valid = 1'b0; id_ready = 1'b0;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0;
        repeat (2) @(negedge clk);
        slots.delete(); mem_q.delete(); log_q.delete();
        drop_m = 0; ref_pc = RST_PC; last_due = cyc;
        rst = 1'b1;
    endtask

    // Called just after a falling edge: drive inputs, then check outputs against the model.
    task automatic drive_and_check(input bit dbg, input bit redir, input logic [31:0] rpc,
                                   input bit idr, input bit reqr);
        c_dbg = dbg; c_redir = redir; c_rpc = rpc; c_idr = idr; c_reqr = reqr;
        dbg_run = dbg; redirect_valid = redir; redirect_pc = rpc;
        id_ready = idr; imem_req_ready = reqr;
        c_rsp = 1'b0;
        imem_rsp_data = $urandom;
        if (mem_q.size() > 0) begin
            if (mem_q[0].due <= cyc) begin
                c_rsp = 1'b1;
                imem_rsp_data = memf(mem_q[0].addr);
            end
        end
        imem_rsp_valid = c_rsp;
        #1;
        c_erv = dbg && !redir && (slots.size() < DEPTH);
        c_eiv = 1'b0;
        if (slots.size() > 0) c_eiv = dbg && !redir && slots[0].landed;
        chk("req_valid", 32'(imem_req_valid), 32'(c_erv));
        chk("req_addr", imem_req_addr, ref_pc);
        chk("pc_out", pc_out, ref_pc);
        chk("occupancy", 32'(occupancy), slots.size());
        chk("id_valid", 32'(id_valid), 32'(c_eiv));
        if (c_eiv) begin
            chk("id_pc_plus4", id_pc_plus4, slots[0].addr + 32'd4);
            chk("id_instr", id_instr, memf(slots[0].addr));
        end
    endtask

    task automatic advance();
        bit dut_fire;
        bit dut_pop;
        int due;
        int pend;
        dut_fire = imem_req_valid && imem_req_ready;
        dut_pop  = id_valid && id_ready;
        if (c_rsp) void'(mem_q.pop_front());
        if (dut_fire) begin
            due = cyc + int'($urandom_range(lat_max, lat_min));
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            mem_q.push_back('{imem_req_addr, due});
        end
        if (dut_pop) log_q.push_back(id_pc_plus4);
        if (c_redir) begin
            pend = 0;
            foreach (slots[i]) if (!slots[i].landed) pend++;
            drop_m += pend;
            if (c_rsp && drop_m > 0) drop_m--;
            slots.delete();
            ref_pc = c_rpc & 32'hFFFF_FFFC;
        end else begin
            if (c_rsp) begin
                if (drop_m > 0) drop_m--;
                else begin
                    for (int i = 0; i < slots.size(); i++) begin
                        if (!slots[i].landed) begin
                            slots[i].landed = 1'b1;
                            break;
                        end
                    end
                end
            end
            if (c_eiv && c_idr) void'(slots.pop_front());
            if (c_erv && c_reqr) begin
                slots.push_back('{ref_pc, 1'b0});
                ref_pc += 32'd4;
            end
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic step(input bit dbg, input bit redir, input logic [31:0] rpc,
                        input bit idr, input bit reqr);
        drive_and_check(dbg, redir, rpc, idr, reqr);
        advance();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] wexp[3];
        bit found;

        // Reset state, checked while reset is held.
        #1 rst = 1'b0;
        #1;
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_id_valid", 32'(id_valid), 32'd0);
        chk("rst_occupancy", 32'(occupancy), 32'd0);
        chk("rst_id_instr", id_instr, 32'd0);
        chk("rst_id_pc_plus4", id_pc_plus4, 32'd0);
        chk("rst_pc_out", pc_out, RST_PC);

        // Directed table: latency-1 memory, startup then a 20-cycle ID stall and release.
        tbl[0]  = '{1,  1'b1, 1'b1, 32'h100, 1'b0, 32'h0,   0};
        tbl[1]  = '{1,  1'b1, 1'b1, 32'h104, 1'b0, 32'h0,   1};
        tbl[2]  = '{1,  1'b1, 1'b1, 32'h108, 1'b1, 32'h104, 2};
        tbl[3]  = '{1,  1'b1, 1'b1, 32'h10C, 1'b1, 32'h108, 2};
        tbl[4]  = '{1,  1'b0, 1'b1, 32'h110, 1'b1, 32'h10C, 2};
        tbl[5]  = '{1,  1'b0, 1'b1, 32'h114, 1'b1, 32'h10C, 3};
        tbl[6]  = '{18, 1'b0, 1'b0, 32'h118, 1'b1, 32'h10C, 4};
        tbl[7]  = '{1,  1'b1, 1'b0, 32'h118, 1'b1, 32'h10C, 4};
        tbl[8]  = '{1,  1'b1, 1'b1, 32'h118, 1'b1, 32'h110, 3};
        tbl[9]  = '{1,  1'b1, 1'b1, 32'h11C, 1'b1, 32'h114, 3};
        tbl[10] = '{1,  1'b1, 1'b1, 32'h120, 1'b1, 32'h118, 3};
        tbl[11] = '{1,  1'b1, 1'b1, 32'h124, 1'b1, 32'h11C, 3};
        lat_min = 1; lat_max = 1;
        do_reset();
        for (int r = 0; r < 12; r++) begin
            for (int k = 0; k < tbl[r].reps; k++) begin
                drive_and_check(1'b1, 1'b0, 32'h0, tbl[r].idr, 1'b1);
                chk("t_req_valid", 32'(imem_req_valid), 32'(tbl[r].rv));
                chk("t_req_addr", imem_req_addr, tbl[r].addr);
                chk("t_id_valid", 32'(id_valid), 32'(tbl[r].iv));
                chk("t_occupancy", 32'(occupancy), tbl[r].occ);
                if (tbl[r].iv) begin
                    chk("t_id_pc_plus4", id_pc_plus4, tbl[r].pc4);
                    chk("t_id_instr", id_instr, memf(tbl[r].pc4 - 32'd4));
                end
                advance();
            end
        end

        // Redirect with three fetches in flight: stale responses must never reach ID.
        lat_min = 4; lat_max = 4;
        do_reset();
        repeat (3) step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
        step(1'b1, 1'b1, 32'h2002, 1'b1, 1'b1);
        drive_and_check(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
        chk("redir_addr", imem_req_addr, 32'h2000);
        advance();
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            drive_and_check(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
            if (id_valid) begin
                found = 1'b1;
                chk("redir_pc_plus4", id_pc_plus4, 32'h2004);
                chk("redir_instr", id_instr, memf(32'h2000));
            end
            advance();
        end
        chk("redir_seen", 32'(found), 32'd1);

        // Address wrap at the top of the address space.
        lat_min = 1; lat_max = 1;
        step(1'b1, 1'b1, 32'hFFFF_FFF8, 1'b1, 1'b1);
        log_q.delete();
        wexp[0] = 32'hFFFF_FFF8; wexp[1] = 32'hFFFF_FFFC; wexp[2] = 32'h0;
        for (int i = 0; i < 3; i++) begin
            drive_and_check(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
            chk("wrap_addr", imem_req_addr, wexp[i]);
            advance();
        end
        repeat (12) step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
        chk("wrap_count", 32'(log_q.size() >= 2), 32'd1);
        if (log_q.size() >= 2) begin
            chk("wrap_pc4_a", log_q[0], 32'hFFFF_FFFC);
            chk("wrap_pc4_b", log_q[1], 32'h0);
        end

        // Debugger freeze with two fetches in flight, then resume.
        lat_min = 3; lat_max = 3;
        do_reset();
        repeat (2) step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++) begin
            drive_and_check(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
            chk("frz_req_valid", 32'(imem_req_valid), 32'd0);
            chk("frz_id_valid", 32'(id_valid), 32'd0);
            if (i == 5) chk("frz_occupancy", 32'(occupancy), 32'd2);
            advance();
        end
        log_q.delete();
        repeat (8) step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
        chk("frz_count", 32'(log_q.size() >= 4), 32'd1);
        if (log_q.size() >= 4) begin
            for (int i = 0; i < 4; i++) chk("frz_order", log_q[i], 32'h104 + 32'(4 * i));
        end

        // Reset asserted mid-stream with responses pending.
        do_reset();
        repeat (5) step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
        rst = 1'b0;
        #1;
        chk("mid_req_valid", 32'(imem_req_valid), 32'd0);
        chk("mid_id_valid", 32'(id_valid), 32'd0);
        chk("mid_occupancy", 32'(occupancy), 32'd0);
        chk("mid_id_instr", id_instr, 32'd0);
        chk("mid_id_pc_plus4", id_pc_plus4, 32'd0);
        do_reset();
        drive_and_check(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
        chk("mid_restart_addr", imem_req_addr, RST_PC);
        advance();
        repeat (8) step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
        chk("mid_count", 32'(log_q.size() >= 2), 32'd1);
        if (log_q.size() >= 2) begin
            chk("mid_first", log_q[0], 32'h104);
            chk("mid_second", log_q[1], 32'h108);
        end

        // Randomized traffic: variable latency, stalls, freezes and redirects.
        lat_min = 1; lat_max = 5;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] rpc;
            rpc = $urandom;
            if ($urandom_range(3, 0) == 0) rpc = 32'hFFFF_FFE0 | (rpc & 32'h1F);
            step($urandom_range(9, 0) != 0, $urandom_range(24, 0) == 0, rpc,
                 $urandom_range(9, 0) < 7, $urandom_range(9, 0) < 7);
        end
        chk("rand_progress", 32'(log_q.size() > 50), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
